// File: rtl/grid_write_arbiter_if.sv
// Bundle between the game-logic requesters and the grid write arbiter.
// The master side drives requests, the window and clear control; the slave side returns grants and the grid write.
interface grid_write_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic                      win;
    logic                      clear_start;
    logic                      clear_busy;
    logic                      clear_done;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          gnt;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    modport master (
        output win, clear_start, req, req_addr, req_data,
        input  clear_busy, clear_done, gnt, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  win, clear_start, req, req_addr, req_data,
        output clear_busy, clear_done, gnt, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/grid_write_arbiter.sv
// Round-robin arbiter for the single grid-store write port, with a window-gated full-grid clear sequencer.
// Grants are combinational; the grid write is registered and lands one cycle after its grant.
module grid_write_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int GRID_CELLS = 768,
    parameter int CLEAR_DATA = 0,
    parameter bit GATE_WIN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    grid_write_arbiter_if.slave  bus
);
    localparam int P_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_CELLS - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    state_e            state_q, state_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              open_win;
    logic              gnt_vld;
    logic [P_W-1:0]    gnt_idx;
    logic [P_W:0]      cand;
    logic [P_W:0]      p_nxt;
    logic [N_REQ-1:0]  gnt_c;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    assign open_win = !GATE_WIN || bus.win;

    // Rotating search starting at p; the first pending requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, p_q} + (P_W+1)'(k);
            if (cand >= (P_W+1)'(N_REQ)) begin
                cand = cand - (P_W+1)'(N_REQ);
            end
            if (!gnt_vld && bus.req[cand[P_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[P_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        if (rst_n && state_q == ST_IDLE && !bus.clear_start && open_win && gnt_vld) begin
            gnt_c[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        p_nxt     = {1'b0, gnt_idx} + (P_W+1)'(1);
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (open_win && gnt_vld) begin
                    p_d       = (p_nxt == (P_W+1)'(N_REQ)) ? '0 : p_nxt[P_W-1:0];
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_arr[gnt_idx];
                    wr_data_d = data_arr[gnt_idx];
                end
            end
            ST_CLEAR: begin
                // Closed-window cycles simply stall the sweep.
                if (open_win) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = DATA_W'(CLEAR_DATA);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            p_q       <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.gnt        = gnt_c;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_grid_write_arbiter.sv
// Self-checking bench for grid_write_arbiter: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations (reset, single write, round-robin, gating, clear, abort).
module tb_grid_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grid_write_arbiter_if #(.N_REQ(3), .ADDR_W(10), .DATA_W(4)) bus ();

    grid_write_arbiter #(
        .N_REQ(3), .ADDR_W(10), .DATA_W(4),
        .GRID_CELLS(768), .CLEAR_DATA(0), .GATE_WIN(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who wins, and what the grid write must be one cycle later.
    int m_ptr = 0;
    bit m_clr = 1'b0;
    int m_next = 0;
    bit e_en = 1'b0;
    int e_addr = 0;
    int e_data = 0;
    bit e_done = 1'b0;

    function automatic int pick(input logic [2:0] r, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (r[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_gnt();
        int g;
        if (!rst_n || m_clr || bus.clear_start || !bus.win) return 3'b000;
        g = pick(bus.req, m_ptr);
        if (g < 0) return 3'b000;
        return 3'b001 << g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_clr <= 1'b0; m_next <= 0;
            e_en <= 1'b0; e_addr <= 0; e_data <= 0; e_done <= 1'b0;
        end else begin
            e_en   <= 1'b0;
            e_done <= 1'b0;
            if (m_clr) begin
                if (bus.win) begin
                    e_en   <= 1'b1;
                    e_addr <= m_next;
                    e_data <= 0;
                    m_next <= m_next + 1;
                    if (m_next == 767) begin
                        m_clr  <= 1'b0;
                        e_done <= 1'b1;
                    end
                end
            end else if (bus.clear_start) begin
                m_clr  <= 1'b1;
                m_next <= 0;
            end else if (bus.win && pick(bus.req, m_ptr) >= 0) begin
                e_en   <= 1'b1;
                e_addr <= int'(bus.req_addr[pick(bus.req, m_ptr)*10 +: 10]);
                e_data <= int'(bus.req_data[pick(bus.req, m_ptr)*4 +: 4]);
                m_ptr  <= (pick(bus.req, m_ptr) + 1) % 3;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("gnt", 32'(bus.gnt), 32'(exp_gnt()));
        chk("wr_en", 32'(bus.wr_en), 32'(e_en));
        if (e_en) begin
            chk("wr_addr", 32'(bus.wr_addr), e_addr);
            chk("wr_data", 32'(bus.wr_data), e_data);
        end
        chk("clear_busy", 32'(bus.clear_busy), 32'(m_clr));
        chk("clear_done", 32'(bus.clear_done), 32'(e_done));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_order [6];
    int busy_cycles, clr_wr, done_cnt, quiet_wr, quiet_done, quiet_busy;
    bit seen;

    initial begin
        rr_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bus.win = 1'b1;
        bus.clear_start = 1'b0;
        bus.req = 3'b111;
        bus.req_addr = {10'd102, 10'd101, 10'd100};
        bus.req_data = {4'h3, 4'h2, 4'h1};

        // Reset with every requester pending.
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(bus.clear_busy), 0);
        chk("rst_done", 32'(bus.clear_done), 0);
        step();
        step();
        rst_n = 1'b1;

        // Round-robin from p=0 with all three held.
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(bus.gnt), 32'(rr_order[j]));
            if (j > 0) begin
                chk("rr_wr_en", 32'(bus.wr_en), 1);
                chk("rr_wr_addr", 32'(bus.wr_addr), 100 + ((j - 1) % 3));
            end
            step();
        end
        bus.req = 3'b000;
        @(negedge clk);
        chk("rr_last_addr", 32'(bus.wr_addr), 102);
        step();

        // Single request from requester 1.
        bus.req = 3'b010;
        bus.req_addr[10 +: 10] = 10'd37;
        bus.req_data[4 +: 4] = 4'h5;
        @(negedge clk);
        chk("single_gnt", 32'(bus.gnt), 32'(3'b010));
        step();
        bus.req = 3'b000;
        @(negedge clk);
        chk("single_wr_en", 32'(bus.wr_en), 1);
        chk("single_wr_addr", 32'(bus.wr_addr), 37);
        chk("single_wr_data", 32'(bus.wr_data), 5);
        step();

        // Window gating: held request waits while win is low.
        bus.win = 1'b0;
        bus.req = 3'b001;
        bus.req_addr[0 +: 10] = 10'd200;
        bus.req_data[0 +: 4] = 4'h9;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("gate_gnt", 32'(bus.gnt), 0);
            chk("gate_wr_en", 32'(bus.wr_en), 0);
            step();
        end
        bus.win = 1'b1;
        @(negedge clk);
        chk("gate_open_gnt", 32'(bus.gnt), 32'(3'b001));
        step();
        bus.req = 3'b000;
        @(negedge clk);
        chk("gate_wr_addr", 32'(bus.wr_addr), 200);
        chk("gate_wr_data", 32'(bus.wr_data), 9);
        step();

        // Clear with requester 2 pending and a 10-cycle window drop.
        bus.clear_start = 1'b1;
        bus.req = 3'b100;
        bus.req_addr[20 +: 10] = 10'd55;
        bus.req_data[8 +: 4] = 4'h7;
        @(negedge clk);
        chk("clr_start_gnt", 32'(bus.gnt), 0);
        step();
        bus.clear_start = 1'b0;
        busy_cycles = 0; clr_wr = 0; done_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (bus.clear_busy) busy_cycles++;
            if ((bus.clear_busy || bus.clear_done) && bus.wr_en) clr_wr++;
            if (bus.clear_done) begin
                done_cnt++;
                seen = 1'b1;
                chk("clr_last_addr", 32'(bus.wr_addr), 767);
                chk("clr_then_gnt", 32'(bus.gnt), 32'(3'b100));
            end
            step();
            bus.win = !(c >= 100 && c < 110);
        end
        if (!seen) chk("clr_timeout", 0, 1);
        chk("clr_busy_len", busy_cycles, 778);
        chk("clr_write_cnt", clr_wr, 768);
        chk("clr_done_cnt", done_cnt, 1);
        bus.win = 1'b1;
        bus.req = 3'b000;
        @(negedge clk);
        chk("post_clr_wr_addr", 32'(bus.wr_addr), 55);
        chk("post_clr_wr_data", 32'(bus.wr_data), 7);
        chk("post_clr_done", 32'(bus.clear_done), 0);
        step();

        // Abort a clear at address 300 with reset.
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_addr == 10'd300) seen = 1'b1;
        end
        if (!seen) chk("abort_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wr_en", 32'(bus.wr_en), 0);
        chk("abort_wr_addr", 32'(bus.wr_addr), 0);
        chk("abort_busy", 32'(bus.clear_busy), 0);
        chk("abort_done", 32'(bus.clear_done), 0);
        step();
        step();
        rst_n = 1'b1;
        quiet_wr = 0; quiet_done = 0; quiet_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.wr_en) quiet_wr++;
            if (bus.clear_done) quiet_done++;
            if (bus.clear_busy) quiet_busy++;
            step();
        end
        chk("abort_quiet_wr", quiet_wr, 0);
        chk("abort_quiet_done", quiet_done, 0);
        chk("abort_quiet_busy", quiet_busy, 0);

        // Pointer restarts at 0 after reset.
        bus.req = 3'b001;
        bus.req_addr[0 +: 10] = 10'd3;
        bus.req_data[0 +: 4] = 4'h4;
        @(negedge clk);
        chk("recover_gnt", 32'(bus.gnt), 32'(3'b001));
        step();
        bus.req = 3'b000;
        @(negedge clk);
        chk("recover_wr_addr", 32'(bus.wr_addr), 3);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
